// File: rtl/vector_permute_unit.sv
//------------------------------------------------------------------------------
// Module      : vector_permute_unit
// Description : Two-stage pipelined vector lane permuter (gather / scatter)
//               with valid/ready handshakes on both sides.
//               Optional macro VECTOR_PERMUTE_CONFLICT_CNT_EN adds a saturating
//               32-bit count of output transfers that flagged a scatter
//               conflict.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vector_permute_unit #(
  parameter int LANES = 8,
  parameter int WIDTH = 64,
  parameter int IDX_W = $clog2(LANES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_vld,
  output logic                   in_rdy,
  input  logic                   in_mode,
  input  logic [LANES-1:0]       in_mask,
  input  logic [LANES*IDX_W-1:0] in_idx,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_mask,
  output logic                   out_conflict
`ifdef VECTOR_PERMUTE_CONFLICT_CNT_EN
  ,
  output logic [31:0]            conflict_cnt
`endif
);

  // Row j of the select matrix lists the input lanes that drive output lane j.
  logic [LANES-1:0]       sel_d    [LANES];
  logic [LANES-1:0]       s1_sel_q [LANES];
  logic                   s1_vld_q;
  logic                   s1_mode_q;
  logic [LANES*WIDTH-1:0] s1_data_q;

  logic                   s2_vld_q;
  logic [LANES*WIDTH-1:0] out_data_d;
  logic [LANES*WIDTH-1:0] out_data_q;
  logic [LANES-1:0]       out_mask_d;
  logic [LANES-1:0]       out_mask_q;
  logic                   out_conflict_d;
  logic                   out_conflict_q;

  logic                   s2_adv;
  logic                   s1_adv;

  // No skid buffer: ready ripples combinationally from out_rdy.
  assign s2_adv       = !s2_vld_q || out_rdy;
  assign s1_adv       = !s1_vld_q || s2_adv;
  assign in_rdy       = s1_adv;
  assign out_vld      = s2_vld_q;
  assign out_data     = out_data_q;
  assign out_mask     = out_mask_q;
  assign out_conflict = out_conflict_q;

  // Decode indices into a one-hot select matrix; the mask is folded in here.
  // Out-of-range indices never match any lane, so they behave as masked off.
  always_comb begin
    sel_d = '{default: '0};
    for (int j = 0; j < LANES; j++) begin
      for (int i = 0; i < LANES; i++) begin
        if (in_mode) begin
          sel_d[j][i] = in_mask[i] && (in_idx[i*IDX_W +: IDX_W] == IDX_W'(j));
        end else begin
          sel_d[j][i] = in_mask[j] && (in_idx[j*IDX_W +: IDX_W] == IDX_W'(i));
        end
      end
    end
  end

  // Stage 1 register: capture the transaction whenever the stage may advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q  <= 1'b0;
      s1_mode_q <= 1'b0;
      s1_data_q <= '0;
      s1_sel_q  <= '{default: '0};
    end else if (s1_adv) begin
      s1_vld_q <= in_vld;
      if (in_vld) begin
        s1_mode_q <= in_mode;
        s1_data_q <= in_data;
        s1_sel_q  <= sel_d;
      end
    end
  end

  // Crossbar: lowest-numbered selected input wins; >=2 selects is a conflict.
  always_comb begin : crossbar
    logic [LANES-1:0] row;
    logic             taken;
    out_data_d     = '0;
    out_mask_d     = '0;
    out_conflict_d = 1'b0;
    row            = '0;
    taken          = 1'b0;
    for (int j = 0; j < LANES; j++) begin
      row   = s1_sel_q[j];
      taken = 1'b0;
      for (int i = 0; i < LANES; i++) begin
        if (row[i] && !taken) begin
          out_data_d[j*WIDTH +: WIDTH] = s1_data_q[i*WIDTH +: WIDTH];
          taken = 1'b1;
        end
      end
      out_mask_d[j] = |row;
      // Gather rows can only ever hold one bit; gating on mode keeps the
      // conflict flag meaningful only for scatter.
      if (s1_mode_q && ((row & (row - LANES'(1))) != '0)) begin
        out_conflict_d = 1'b1;
      end
    end
  end

  // Stage 2 register: outputs hold stable while stalled by out_rdy.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_vld_q       <= 1'b0;
      out_data_q     <= '0;
      out_mask_q     <= '0;
      out_conflict_q <= 1'b0;
    end else if (s2_adv) begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        out_data_q     <= out_data_d;
        out_mask_q     <= out_mask_d;
        out_conflict_q <= out_conflict_d;
      end
    end
  end

`ifdef VECTOR_PERMUTE_CONFLICT_CNT_EN
  logic [31:0] conflict_cnt_q;

  // Saturating count of delivered vectors that reported a scatter conflict.
  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_cnt_q <= '0;
    end else if (out_vld_xfer_conflict() && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
      conflict_cnt_q <= conflict_cnt_q + 32'd1;
    end
  end

  function automatic logic out_vld_xfer_conflict();
    return s2_vld_q && out_rdy && out_conflict_q;
  endfunction

  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

`default_nettype wire
